// File: rtl/seg7_time_reader.sv
// rtl/seg7_time_reader.sv - decodes six 7-segment digits back to BCD time and
// publishes each settled value once, with range/sequence/illegal-pattern checks.
module seg7_time_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [6:0]  H1disp,
   input  logic [6:0]  H0disp,
   input  logic [6:0]  M1disp,
   input  logic [6:0]  M0disp,
   input  logic [6:0]  S1disp,
   input  logic [6:0]  S0disp,
   output logic [23:0] Time,
   output logic        Valid,
   output logic        RangeErr,
   output logic        SeqErr,
   output logic [7:0]  ErrCount
);

   localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

   typedef enum logic {SEEK, LOCK} state_t;

   state_t      state_q, state_d;
   logic [23:0] cand_q, cand_d;
   logic [3:0]  run_q, run_d;
   logic        have_q, have_d;
   logic [23:0] time_q, time_d;
   logic        valid_q, valid_d;
   logic        rerr_q, rerr_d;
   logic        serr_q, serr_d;
   logic [7:0]  err_q, err_d;

   // Returns {legal, digit}; blank_ok lets an all-off pattern read as 0.
   function automatic logic [4:0] dec_digit(input logic [6:0] seg, input logic blank_ok);
      logic [4:0] r;
      case (seg)
         7'h3F:   r = {1'b1, 4'd0};
         7'h06:   r = {1'b1, 4'd1};
         7'h5B:   r = {1'b1, 4'd2};
         7'h4F:   r = {1'b1, 4'd3};
         7'h66:   r = {1'b1, 4'd4};
         7'h6D:   r = {1'b1, 4'd5};
         7'h7D:   r = {1'b1, 4'd6};
         7'h07:   r = {1'b1, 4'd7};
         7'h7F:   r = {1'b1, 4'd8};
         7'h6F:   r = {1'b1, 4'd9};
         7'h00:   r = {blank_ok, 4'd0};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   function automatic logic in_range(input logic [23:0] t);
      logic hours_ok;
      hours_ok = (t[23:20] <= 4'd1 && t[19:16] <= 4'd9) ||
                 (t[23:20] == 4'd2 && t[19:16] <= 4'd3);
      return hours_ok && t[15:12] <= 4'd5 && t[11:8] <= 4'd9 &&
             t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
   endfunction

   // Only meaningful for in-range input; callers gate on in_range first.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      r = t;
      if (t[3:0] != 4'd9) begin
         r[3:0] = t[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (t[7:4] != 4'd5) begin
            r[7:4] = t[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (t[11:8] != 4'd9) begin
               r[11:8] = t[11:8] + 4'd1;
            end else begin
               r[11:8] = 4'd0;
               if (t[15:12] != 4'd5) begin
                  r[15:12] = t[15:12] + 4'd1;
               end else begin
                  r[15:12] = 4'd0;
                  if (t[23:20] == 4'd2 && t[19:16] == 4'd3) begin
                     r[23:16] = 8'h00;
                  end else if (t[19:16] == 4'd9) begin
                     r[19:16] = 4'd0;
                     r[23:20] = t[23:20] + 4'd1;
                  end else begin
                     r[19:16] = t[19:16] + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   logic [4:0]  d_h1, d_h0, d_m1, d_m0, d_s1, d_s0;
   logic        sample_ok;
   logic [23:0] dec;
   logic [3:0]  run_inc;

   always_comb begin
      d_h1      = dec_digit(H1disp, 1'b1);
      d_h0      = dec_digit(H0disp, 1'b0);
      d_m1      = dec_digit(M1disp, 1'b0);
      d_m0      = dec_digit(M0disp, 1'b0);
      d_s1      = dec_digit(S1disp, 1'b0);
      d_s0      = dec_digit(S0disp, 1'b0);
      sample_ok = d_h1[4] & d_h0[4] & d_m1[4] & d_m0[4] & d_s1[4] & d_s0[4];
      dec       = {d_h1[3:0], d_h0[3:0], d_m1[3:0], d_m0[3:0], d_s1[3:0], d_s0[3:0]};
      run_inc   = run_q + 4'd1;
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      run_d   = run_q;
      have_d  = have_q;
      time_d  = time_q;
      valid_d = 1'b0;
      rerr_d  = rerr_q;
      serr_d  = serr_q;
      err_d   = err_q;
      if (!sample_ok) begin
         run_d   = 4'd0;
         state_d = SEEK;
         if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end else if (dec != cand_q) begin
         cand_d  = dec;
         run_d   = 4'd1;
         state_d = SEEK;
      end else if (state_q == SEEK) begin
         if (run_inc >= STABLE_N) begin
            run_d   = STABLE_N;
            state_d = LOCK;
            // A settle back onto the already-published value stays silent.
            if (!have_q || cand_q != time_q) begin
               time_d  = cand_q;
               valid_d = 1'b1;
               have_d  = 1'b1;
               rerr_d  = !in_range(cand_q);
               serr_d  = have_q && in_range(time_q) && in_range(cand_q) &&
                         (cand_q != bcd_inc(time_q));
            end
         end else begin
            run_d = run_inc;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= SEEK;
         cand_q  <= 24'd0;
         run_q   <= 4'd0;
         have_q  <= 1'b0;
         time_q  <= 24'd0;
         valid_q <= 1'b0;
         rerr_q  <= 1'b0;
         serr_q  <= 1'b0;
         err_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         run_q   <= run_d;
         have_q  <= have_d;
         time_q  <= time_d;
         valid_q <= valid_d;
         rerr_q  <= rerr_d;
         serr_q  <= serr_d;
         err_q   <= err_d;
      end
   end

   assign Time     = time_q;
   assign Valid    = valid_q;
   assign RangeErr = rerr_q;
   assign SeqErr   = serr_q;
   assign ErrCount = err_q;

endmodule

// File: tb/tb_seg7_time_reader.sv
// tb/tb_seg7_time_reader.sv - scoreboard bench: stimulus queues expected
// publishes, a monitor pops and checks them whenever Valid is seen.
module tb_seg7_time_reader;

   localparam int STABLE = 4;

   logic        Clk;
   logic        Reset;
   logic [6:0]  H1disp, H0disp, M1disp, M0disp, S1disp, S0disp;
   logic [23:0] Time;
   logic        Valid, RangeErr, SeqErr;
   logic [7:0]  ErrCount;

   seg7_time_reader #(.STABLE_CYCLES(STABLE)) dut (
      .Clk(Clk), .Reset(Reset),
      .H1disp(H1disp), .H0disp(H0disp), .M1disp(M1disp),
      .M0disp(M0disp), .S1disp(S1disp), .S0disp(S0disp),
      .Time(Time), .Valid(Valid), .RangeErr(RangeErr),
      .SeqErr(SeqErr), .ErrCount(ErrCount)
   );

   typedef struct {
      logic [23:0] t;
      logic        r;
      logic        s;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 7'h3F;  4'd1: seg = 7'h06;  4'd2: seg = 7'h5B;
         4'd3: seg = 7'h4F;  4'd4: seg = 7'h66;  4'd5: seg = 7'h6D;
         4'd6: seg = 7'h7D;  4'd7: seg = 7'h07;  4'd8: seg = 7'h7F;
         4'd9: seg = 7'h6F;  default: seg = 7'h00;
      endcase
   endfunction

   task automatic drive(input logic [23:0] t);
      H1disp = seg(t[23:20]);
      H0disp = seg(t[19:16]);
      M1disp = seg(t[15:12]);
      M0disp = seg(t[11:8]);
      S1disp = seg(t[7:4]);
      S0disp = seg(t[3:0]);
   endtask

   // Called at the negedge where the pattern is applied; strobe is seen
   // at the negedge following the STABLE-th rising edge.
   task automatic expect_pub(input logic [23:0] t, input logic r, input logic s);
      q.push_back('{t, r, s, cyc + STABLE});
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge Clk);
   endtask

   always @(negedge Clk) begin
      if (Valid) begin
         chk("valid_spacing", {31'd0, prev_valid}, 32'd0);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid actual=%h required=none", Time);
         end else begin
            chk("pub_cycle", q[0].cyc, cyc);
            chk("pub_time", {8'd0, Time}, {8'd0, q[0].t});
            chk("pub_range", {31'd0, RangeErr}, {31'd0, q[0].r});
            chk("pub_seq", {31'd0, SeqErr}, {31'd0, q[0].s});
            q.delete(0);
         end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
         total++;
         bad++;
         $display("FAIL missed_valid actual=none required=%h", q[0].t);
         q.delete(0);
      end
      prev_valid <= Valid;
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_time"}, {8'd0, Time}, 32'd0);
      chk({tag, "_valid"}, {31'd0, Valid}, 32'd0);
      chk({tag, "_range"}, {31'd0, RangeErr}, 32'd0);
      chk({tag, "_seq"}, {31'd0, SeqErr}, 32'd0);
      chk({tag, "_errcnt"}, {24'd0, ErrCount}, 32'd0);
   endtask

   initial begin
      Reset = 1'b1;
      drive(24'h123456);
      @(negedge Clk);
      chk_zero("reset");
      Reset = 1'b0;
      expect_pub(24'h123456, 1'b0, 1'b0);
      hold(6);

      drive(24'h123457); expect_pub(24'h123457, 1'b0, 1'b0); hold(6);
      drive(24'h123459); expect_pub(24'h123459, 1'b0, 1'b1); hold(6);
      drive(24'h123500); expect_pub(24'h123500, 1'b0, 1'b0); hold(6);
      drive(24'h235959); expect_pub(24'h235959, 1'b0, 1'b1); hold(6);
      drive(24'h000000); H1disp = 7'h00;
      expect_pub(24'h000000, 1'b0, 1'b0); hold(6);
      drive(24'h123456); expect_pub(24'h123456, 1'b0, 1'b1); hold(6);

      // short excursion and return: silent relock
      drive(24'h123457); hold(3);
      drive(24'h123456); hold(6);

      drive(24'h123456); S0disp = 7'h01; hold(2);
      chk("errcnt_two", {24'd0, ErrCount}, 32'd2);
      drive(24'h123456); hold(6);
      chk("errcnt_after_relock", {24'd0, ErrCount}, 32'd2);

      // illegal sample on the edge that would complete the run
      drive(24'h123458); hold(3);
      S0disp = 7'h01; hold(1);
      chk("errcnt_collide", {24'd0, ErrCount}, 32'd3);
      drive(24'h123456); hold(6);

      S0disp = 7'h01; hold(300);
      chk("errcnt_sat", {24'd0, ErrCount}, 32'd255);
      drive(24'h123456); hold(6);

      drive(24'h256100); expect_pub(24'h256100, 1'b1, 1'b0); hold(6);
      chk("range_held", {31'd0, RangeErr}, 32'd1);
      drive(24'h120000); expect_pub(24'h120000, 1'b0, 1'b0); hold(6);

      drive(24'h123456); hold(3);
      #2 Reset = 1'b1;
      #1 chk_zero("midreset");
      @(negedge Clk);
      Reset = 1'b0;
      expect_pub(24'h123456, 1'b0, 1'b0);
      hold(6);

      hold(4);
      chk("queue_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
